// File: rtl/ir_presence_if.sv
// Signal bundle between the IR presence conditioner and its controlling logic:
// enable/clear controls and raw sensor in, conditioned presence information out.
interface ir_presence_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             ir_raw;
    logic             cnt_clr;
    logic             presence;
    logic             detect_pulse;
    logic [CNT_W-1:0] event_count;
    logic [2:0]       state_o;

    modport master (
        output enable,
        output ir_raw,
        output cnt_clr,
        input  presence,
        input  detect_pulse,
        input  event_count,
        input  state_o
    );

    modport slave (
        input  enable,
        input  ir_raw,
        input  cnt_clr,
        output presence,
        output detect_pulse,
        output event_count,
        output state_o
    );
endinterface

// File: rtl/ir_presence_conditioner.sv
// Conditions a raw IR/PIR sensor into a clean presence level: synchronizes, rejects
// short glitches, holds presence after the sensor drops, then blanks before re-arming.
module ir_presence_conditioner #(
    parameter int GLITCH_T = 8,
    parameter int HOLD_T   = 2000,
    parameter int BLANK_T  = 500,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    ir_presence_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUALIFY = 3'd1,
        ACTIVE  = 3'd2,
        HOLD    = 3'd3,
        BLANK   = 3'd4
    } state_t;

    // One timer is shared by the qualify, hold and blank phases since they never overlap.
    localparam int MAX_GH = (GLITCH_T > HOLD_T) ? GLITCH_T : HOLD_T;
    localparam int MAX_T  = (MAX_GH > BLANK_T) ? MAX_GH : BLANK_T;
    localparam int TMR_W  = (MAX_T > 2) ? $clog2(MAX_T) : 1;

    localparam logic [TMR_W-1:0] QUAL_LAST  = TMR_W'(GLITCH_T - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_T - 1);
    localparam logic [TMR_W-1:0] BLANK_LAST = TMR_W'(BLANK_T - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0]       sync_q;
    logic             ir_s;
    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             pulse_q;
    logic [CNT_W-1:0] event_cnt;
    logic             qualified;

    assign ir_s      = sync_q[1];
    assign qualified = bus.enable && (state == QUALIFY) && ir_s && (timer >= QUAL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.ir_raw};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            timer   <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (!bus.enable) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ir_s) begin
                            state <= QUALIFY;
                            timer <= TMR_ONE;
                        end else begin
                            timer <= '0;
                        end
                    end
                    QUALIFY: begin
                        if (!ir_s) begin
                            state <= IDLE;
                            timer <= '0;
                        end else if (timer >= QUAL_LAST) begin
                            state   <= ACTIVE;
                            timer   <= '0;
                            pulse_q <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (!ir_s) begin
                            state <= HOLD;
                            timer <= '0;
                        end
                    end
                    // Retrigger is tested first so it beats a coincident hold expiry.
                    HOLD: begin
                        if (ir_s) begin
                            state <= ACTIVE;
                            timer <= '0;
                        end else if (timer == HOLD_LAST) begin
                            state <= BLANK;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    BLANK: begin
                        if (timer == BLANK_LAST) begin
                            state <= IDLE;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            event_cnt <= '0;
        end else if (bus.cnt_clr) begin
            event_cnt <= '0;
        end else if (qualified && (event_cnt != CNT_MAX)) begin
            event_cnt <= event_cnt + 1'b1;
        end
    end

    assign bus.presence     = (state == ACTIVE) || (state == HOLD);
    assign bus.detect_pulse = pulse_q;
    assign bus.event_count  = event_cnt;
    assign bus.state_o      = state;

endmodule
